dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipelined LEGv8 core.
- Accepts the stage's load/store request (ALU result as address, read_data_2 as store data, MemRead/MemWrite) and services it after a programmable latency.
- Drives a stall back to the pipeline so the IF/ID/EX/MEM registers hold until the response is ready.
- Holds DEPTH doublewords of storage.

Parameters:
DEPTH, 64, number of 64-bit doublewords stored (power of two, >=2)
LATENCY, 3, BUSY cycles per access (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
mem_read  input  1  load request (MEM_MemRead)
mem_write  input  1  store request (MEM_MemWrite)
address  input  64  byte address (MEM_ALUResult)
write_data  input  64  store data (MEM_read_data_2)
read_data  output  64  load result, valid while resp_valid=1
resp_valid  output  1  one-cycle response pulse (state DONE)
stall  output  1  hold all pipeline registers while 1
err  output  1  sticky: out-of-range, misaligned, or read+write collision

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time including mid-access):
  - state=IDLE; read_data=0; resp_valid=0; err=0; stall=0.
  - An in-flight store that has not yet committed is dropped.
  - Storage contents are not cleared.
- FSM states IDLE, BUSY, DONE:
  - IDLE, req=(mem_read|mem_write)=0: stay; stall=0.
  - IDLE, req=1: stall=1 combinationally in the same cycle. Latch address, write_data and op. Load cnt=LATENCY-1. Go to BUSY.
  - BUSY: stall=1; cnt decrements each cycle.
  - BUSY, cnt==0: on that edge the store commits, or the load data is registered into read_data. Go to DONE.
  - DONE: stall=0; resp_valid=1; read_data holds the loaded value (unchanged after a store). The pipeline advances on this edge. Always go to IDLE next.
- Timing:
  - Request first seen in cycle 0 → stall high in cycles 0..LATENCY; resp_valid in cycle LATENCY+1.
  - Back-to-back requests cost LATENCY+2 cycles each: one idle cycle between accesses.
- Inputs are sampled only in IDLE. Changes during BUSY are ignored because the pipeline is held.
- Addressing: index = address[3+log2(DEPTH)-1:3].
  - address[2:0]!=0: access proceeds with the low bits ignored; err set.
  - address >= 8*DEPTH: load returns 0, store is dropped, err set; latency is unchanged.
- mem_read and mem_write both 1: treated as a store; err set.
- err clears only on reset.
- read_data holds its last value outside DONE.

Optional Feature:
- Macro DMEM_HIT_BYPASS_EN.
- When defined:
  - A one-entry tag (last completed in-range index plus valid bit, cleared on reset) is kept.
  - A load in IDLE whose index matches the tag goes IDLE→DONE directly, skipping BUSY. stall=1 for cycle 0 only; resp_valid in cycle 1.
  - Every completed in-range access, load or store, updates the tag.
  - Stores and all other loads behave as the base design.
- When undefined: no tag logic; every access takes the full LATENCY path.

Test Plan:
- Reset: hold reset_n=0 → stall=0, resp_valid=0, read_data=0, err=0. Release reset_n → state IDLE.
- Store then load, LATENCY=3, address 0x10:
  - Store 0xDEADBEEF_00000001: stall high 4 cycles, resp_valid on cycle 4.
  - Subsequent load of 0x10: read_data=0xDEADBEEF_00000001 with resp_valid, err=0.
- Boundaries, DEPTH=64:
  - Load 0x1F8 after storing 0x55 there → 0x55.
  - Load 0x200 → read_data=0, err=1.
  - Store to 0x200 → storage unchanged.
- Misaligned store to 0x13 of value 7 → load of 0x10 returns 7; err=1.
- Reset mid-access: assert reset_n=0 during BUSY of a store 0xAA to 0x08 → after reset, load 0x08 returns the prior value (not 0xAA); stall=0 immediately on reset.
- With DMEM_HIT_BYPASS_EN: store 0x08 then load 0x08 → stall=1 for one cycle, resp_valid next cycle with the stored value. Load 0x10 (no hit) → full LATENCY+1 stall.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage of the
// pipelined LEGv8 core. It accepts a load/store request, holds the pipeline
// with stall for LATENCY+1 cycles, then pulses resp_valid for one cycle.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   mem_read   - load request (MEM_MemRead)
//   mem_write  - store request (MEM_MemWrite)
//   address    - byte address (MEM_ALUResult)
//   write_data - store data (MEM_read_data_2)
//   read_data  - load result, valid while resp_valid=1, held otherwise
//   resp_valid - one-cycle response pulse
//   stall      - hold all pipeline registers while 1
//   err        - sticky: out-of-range, misaligned, or read+write collision
//
// Optional feature: define DMEM_HIT_BYPASS_EN to add a one-entry index tag;
// a load hitting the tag completes in one stall cycle, skipping BUSY.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        resp_valid,
  output logic        stall,
  output logic        err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   idx_q;
  logic            wr_q;
  logic            oor_q;
  logic [63:0]     wdata_q;
  logic [63:0]     mem [DEPTH];

  logic            req, in_oor, in_misal, in_coll;
  logic [AW-1:0]   in_idx;
  logic            accept, finish, hit, hit_take;

  assign req      = mem_read | mem_write;
  assign in_idx   = address[AW+2:3];
  assign in_oor   = |address[63:AW+3];
  assign in_misal = |address[2:0];
  assign in_coll  = mem_read & mem_write;

`ifdef DMEM_HIT_BYPASS_EN
  logic [AW-1:0] tag_idx;
  logic          tag_vld;

  // Only a pure, in-range load may use the bypass; the tag only ever holds
  // in-range indices, so an out-of-range alias must not match it.
  assign hit = tag_vld && (tag_idx == in_idx) && mem_read && !mem_write && !in_oor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_idx <= '0;
      tag_vld <= 1'b0;
    end else if (finish && !oor_q) begin
      tag_idx <= idx_q;
      tag_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    hit_take   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall  = 1'b1;
          accept = 1'b1;
          if (hit) begin
            hit_take = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      oor_q     <= 1'b0;
      wdata_q   <= '0;
      read_data <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= in_idx;
        wr_q    <= mem_write;
        oor_q   <= in_oor;
        wdata_q <= write_data;
        cnt_q   <= CW'(LATENCY - 1);
        if (in_oor || in_misal || in_coll) err <= 1'b1;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (finish && !wr_q) read_data <= oor_q ? '0 : mem[idx_q];
      if (hit_take)        read_data <= mem[in_idx];
    end
  end

  // Storage is not reset. Commit only happens from BUSY, which reset leaves
  // immediately, so an in-flight store is dropped by an asynchronous reset.
  always_ff @(posedge clk) begin
    if (finish && wr_q && !oor_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [63:0] address = '0, write_data = '0;
  logic [63:0] read_data;
  logic        resp_valid, stall, err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .resp_valid(resp_valid), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;     // apply reset before this access
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;  // read_data during DONE (held value for stores)
    logic        exp_err;
    logic        hit;     // load expected to hit the bypass tag
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic rst, logic rd, logic wr, logic [63:0] a,
                              logic [63:0] wd, logic [63:0] er, logic ee, logic h);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.exp_rd = er; v.exp_err = ee; v.hit = h;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_rdata", read_data, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] exp_rd, input logic exp_err,
                           input int exp_stall);
    int n;
    @(negedge clk);
    mem_read = rd; mem_write = wr; address = a; write_data = wd;
    #1;
    n = 0;
    if (stall) n = 1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    address = $urandom; write_data = {$urandom, $urandom};  // ignored while busy
    while (stall && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    check({tag, "_resp"}, 64'(resp_valid), 64'd1);
    check({tag, "_rdata"}, read_data, exp_rd);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    @(posedge clk); #1;
    check({tag, "_idle_resp"}, 64'(resp_valid), 64'd0);
    check({tag, "_idle_stall"}, 64'(stall), 64'd0);
    check({tag, "_hold_rdata"}, read_data, exp_rd);
  endtask

  function automatic int exp_stall_of(logic h);
`ifdef DMEM_HIT_BYPASS_EN
    return h ? 1 : int'(LAT) + 1;
`else
    return int'(LAT) + 1;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                rst  rd wr  addr     wdata                  exp_rd                 err hit
    vecs[0]  = mk(1'b0, 0, 1, 64'h000, 64'h77,                 64'h0,                 0, 0);
    vecs[1]  = mk(1'b0, 0, 1, 64'h010, 64'hDEADBEEF_00000001, 64'h0,                 0, 0);
    vecs[2]  = mk(1'b0, 1, 0, 64'h010, 64'h0,                 64'hDEADBEEF_00000001, 0, 1);
    vecs[3]  = mk(1'b0, 0, 1, 64'h008, 64'h1234,              64'hDEADBEEF_00000001, 0, 0);
    vecs[4]  = mk(1'b0, 1, 0, 64'h008, 64'h0,                 64'h1234,              0, 1);
    vecs[5]  = mk(1'b0, 1, 0, 64'h010, 64'h0,                 64'hDEADBEEF_00000001, 0, 0);
    vecs[6]  = mk(1'b0, 0, 1, 64'h1F8, 64'h55,                64'hDEADBEEF_00000001, 0, 0);
    vecs[7]  = mk(1'b0, 1, 0, 64'h1F8, 64'h0,                 64'h55,                0, 1);
    vecs[8]  = mk(1'b0, 1, 0, 64'h000, 64'h0,                 64'h77,                0, 0);
    vecs[9]  = mk(1'b0, 1, 0, 64'h200, 64'h0,                 64'h0,                 1, 0);
    vecs[10] = mk(1'b0, 0, 1, 64'h200, 64'h99,                64'h0,                 1, 0);
    vecs[11] = mk(1'b0, 1, 0, 64'h000, 64'h0,                 64'h77,                1, 1);
    vecs[12] = mk(1'b1, 0, 1, 64'h013, 64'h7,                 64'h0,                 1, 0);
    vecs[13] = mk(1'b0, 1, 0, 64'h010, 64'h0,                 64'h7,                 1, 1);
    vecs[14] = mk(1'b1, 1, 0, 64'h010, 64'h0,                 64'h7,                 0, 0);
    vecs[15] = mk(1'b0, 1, 1, 64'h018, 64'h42,                64'h7,                 1, 0);
    vecs[16] = mk(1'b0, 1, 0, 64'h018, 64'h0,                 64'h42,                1, 1);
    vecs[17] = mk(1'b1, 1, 0, 64'h1F8, 64'h0,                 64'h55,                0, 0);

    // power-on reset state
    #3;
    check("por_stall", 64'(stall), 64'd0);
    check("por_resp", 64'(resp_valid), 64'd0);
    check("por_rdata", read_data, 64'd0);
    check("por_err", 64'(err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rst) do_reset();
      do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
                exp_stall_of(vecs[i].hit));
    end

    // reset in the middle of a store: the store must be dropped
    @(negedge clk);
    mem_write = 1'b1; address = 64'h008; write_data = 64'hAA;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_stall", 64'(stall), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_resp", 64'(resp_valid), 64'd0);
    check("mid_rst_rdata", read_data, 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_access("mid_load", 1'b1, 1'b0, 64'h008, 64'h0, 64'h1234, 1'b0, int'(LAT) + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
